// File: rtl/proc_pkg.sv
// proc_pkg: definitions shared by the fetch unit and the processor control FSM.
// Contents: opcode constants, addressing-mode constants, the fetch state enum
// and the instruction length type.
package proc_pkg;

  // Opcodes live in byte0[7:2].
  localparam logic [5:0] OP_LOAD    = 6'b000001;
  localparam logic [5:0] OP_REGLOAD = 6'b000010;
  localparam logic [5:0] OP_JMP     = 6'b001001;
  localparam logic [5:0] OP_BEQL    = 6'b001010;
  localparam logic [5:0] OP_BNEQL   = 6'b001011;
  localparam logic [5:0] OP_POP     = 6'b100100;
  localparam logic [5:0] OP_PUSH    = 6'b100101;
  localparam logic [5:0] OP_ASR     = 6'b101000;
  localparam logic [5:0] OP_LSR     = 6'b101001;
  localparam logic [5:0] OP_ASL     = 6'b101010;
  localparam logic [5:0] OP_LSL     = 6'b101011;
  localparam logic [5:0] OP_ADD     = 6'b110000;
  localparam logic [5:0] OP_SUB     = 6'b110001;
  localparam logic [5:0] OP_MUL     = 6'b110010;
  localparam logic [5:0] OP_AND     = 6'b110011;
  localparam logic [5:0] OP_OR      = 6'b110100;
  localparam logic [5:0] OP_XOR     = 6'b110101;
  localparam logic [5:0] OP_NOT     = 6'b110110;
  localparam logic [5:0] OP_STOP    = 6'b111111;

  // Addressing modes carried in the funct field (byte1[7:5]).
  localparam logic [2:0] AM_REGDIR = 3'b000;
  localparam logic [2:0] AM_MEMDIR = 3'b001;
  localparam logic [2:0] AM_PCREL  = 3'b010;
  localparam logic [2:0] AM_IMMED  = 3'b111;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_REQ  = 2'd1,
    FS_WAIT = 2'd2,
    FS_DONE = 2'd3
  } fetch_state_e;

  // Number of instruction bytes, 1..3 (0 only out of reset).
  typedef logic [1:0] len_t;
  localparam len_t LEN1 = 2'd1;
  localparam len_t LEN2 = 2'd2;
  localparam len_t LEN3 = 2'd3;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: byte-wide program-memory read port.
//   mem_rd     request, held until mem_gnt
//   mem_addr   byte address, stable while mem_rd=1
//   mem_gnt    request accepted this cycle
//   mem_rdata  read data, valid with mem_rvalid
//   mem_rvalid read data valid, one or more cycles after the grant
// master = fetch unit, slave = memory.
interface instr_fetch_unit_if #(parameter int AW = 8);
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic          mem_gnt;
  logic [7:0]    mem_rdata;
  logic          mem_rvalid;

  modport master (output mem_rd, mem_addr, input mem_gnt, mem_rdata, mem_rvalid);
  modport slave  (input mem_rd, mem_addr, output mem_gnt, mem_rdata, mem_rvalid);
endinterface

// File: rtl/instr_len_decode.sv
// instr_len_decode: opcode -> instruction length in bytes.
//   op_i  [5:0] opcode (byte0[7:2])
//   len_o [1:0] 1, 2 or 3; unknown opcodes are treated as 3-byte.
module instr_len_decode
  import proc_pkg::*;
(
  input  logic [5:0] op_i,
  output len_t       len_o
);

  always_comb begin
    len_o = LEN3;
    case (op_i)
      OP_POP, OP_PUSH, OP_ASR, OP_LSR, OP_ASL, OP_LSL, OP_STOP: len_o = LEN1;
      OP_JMP, OP_BEQL, OP_BNEQL:                                len_o = LEN2;
      default:                                                  len_o = LEN3;
    endcase
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: reads one 1..3 byte instruction at PC on each fetch command.
//   clk, reset        clock, synchronous active-high reset
//   start             fetch command (sampled in IDLE only)
//   pc_load/_val      PC load, IDLE only; applied before a same-cycle start
//   mem               program-memory read port (master side)
//   busy              high while the fetch is in progress (REQ/WAIT)
//   done              one-cycle pulse, fields below valid
//   op/funct/regsel/operand/len  decoded fields of the last instruction
//   pc                current PC (advanced by one per byte read)
module instr_fetch_unit
  import proc_pkg::*;
#(
  parameter int            AW       = 8,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          pc_load,
  input  logic [AW-1:0] pc_load_val,
  instr_fetch_unit_if.master mem,
  output logic          busy,
  output logic          done,
  output logic [5:0]    op,
  output logic [2:0]    funct,
  output logic [4:0]    regsel,
  output logic [7:0]    operand,
  output len_t          len,
  output logic [AW-1:0] pc
);

  localparam logic [AW-1:0] PC_ONE = {{(AW-1){1'b0}}, 1'b1};

  fetch_state_e  state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [5:0]    op_q, op_d;
  logic [2:0]    funct_q, funct_d;
  logic [4:0]    regsel_q, regsel_d;
  logic [7:0]    operand_q, operand_d;
  len_t          len_q, len_d;
  len_t          dec_len, cur_len;
  logic [1:0]    unused_rdata_lo;

  assign unused_rdata_lo = mem.mem_rdata[1:0];

  instr_len_decode u_len_dec (
    .op_i  (mem.mem_rdata[7:2]),
    .len_o (dec_len)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pc_d      = pc_q;
    op_d      = op_q;
    funct_d   = funct_q;
    regsel_d  = regsel_q;
    operand_d = operand_q;
    len_d     = len_q;
    // While reading byte0 the length is not latched yet; use the decoder.
    cur_len   = (idx_q == 2'd0) ? dec_len : len_q;
    case (state_q)
      FS_IDLE: begin
        if (pc_load) pc_d = pc_load_val;
        if (start) begin
          state_d = FS_REQ;
          idx_d   = 2'd0;
        end
      end
      FS_REQ: begin
        if (mem.mem_gnt) state_d = FS_WAIT;
      end
      FS_WAIT: begin
        if (mem.mem_rvalid) begin
          pc_d = pc_q + PC_ONE;
          case (idx_q)
            2'd0: begin
              op_d      = mem.mem_rdata[7:2];
              funct_d   = '0;
              regsel_d  = '0;
              operand_d = '0;
              len_d     = dec_len;
            end
            2'd1: begin
              if (len_q == LEN2) begin
                operand_d = mem.mem_rdata;
              end else begin
                funct_d  = mem.mem_rdata[7:5];
                regsel_d = mem.mem_rdata[4:0];
              end
            end
            default: operand_d = mem.mem_rdata;
          endcase
          if ((idx_q + 2'd1) < cur_len) begin
            idx_d   = idx_q + 2'd1;
            state_d = FS_REQ;
          end else begin
            state_d = FS_DONE;
          end
        end
      end
      FS_DONE: state_d = FS_IDLE;
      default: state_d = FS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FS_IDLE;
      idx_q     <= '0;
      pc_q      <= RESET_PC;
      op_q      <= '0;
      funct_q   <= '0;
      regsel_q  <= '0;
      operand_q <= '0;
      len_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pc_q      <= pc_d;
      op_q      <= op_d;
      funct_q   <= funct_d;
      regsel_q  <= regsel_d;
      operand_q <= operand_d;
      len_q     <= len_d;
    end
  end

  assign mem.mem_rd   = (state_q == FS_REQ);
  assign mem.mem_addr = (state_q == FS_REQ) ? pc_q : '0;
  assign busy         = (state_q == FS_REQ) || (state_q == FS_WAIT);
  assign done         = (state_q == FS_DONE);
  assign op           = op_q;
  assign funct        = funct_q;
  assign regsel       = regsel_q;
  assign operand      = operand_q;
  assign len          = len_q;
  assign pc           = pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  import proc_pkg::*;

  typedef struct {
    logic [5:0] op;
    logic [2:0] funct;
    logic [4:0] regsel;
    logic [7:0] operand;
    logic [1:0] len;
    logic [7:0] npc;
  } exp_t;

  logic       clk = 0;
  logic       reset, start, pc_load;
  logic [7:0] pc_load_val;
  logic       busy, done;
  logic [5:0] op;
  logic [2:0] funct;
  logic [4:0] regsel;
  logic [7:0] operand;
  logic [1:0] len;
  logic [7:0] pc;

  instr_fetch_unit_if #(.AW(8)) mif ();

  instr_fetch_unit #(.AW(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .reset(reset), .start(start), .pc_load(pc_load),
    .pc_load_val(pc_load_val), .mem(mif), .busy(busy), .done(done),
    .op(op), .funct(funct), .regsel(regsel), .operand(operand),
    .len(len), .pc(pc));

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int cyc = 0, done_cnt = 0, done_cyc = 0;
  logic [7:0] mem [256];
  logic [7:0] addr_q [$];
  exp_t       exp_r;
  bit         exp_valid = 0;
  logic [7:0] model_pc = 8'h00;
  int         gdly = 0, rdly = 1;
  bit         spur = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Instruction semantics from the byte format and length classes.
  function automatic exp_t predict(input logic [7:0] base);
    exp_t e;
    logic [7:0] a1, a2, b0;
    a1 = base + 8'd1;
    a2 = base + 8'd2;
    b0 = mem[base];
    e.op = b0[7:2];
    if (e.op inside {OP_POP, OP_PUSH, OP_ASR, OP_LSR, OP_ASL, OP_LSL, OP_STOP}) e.len = 2'd1;
    else if (e.op inside {OP_JMP, OP_BEQL, OP_BNEQL}) e.len = 2'd2;
    else e.len = 2'd3;
    e.funct = 0; e.regsel = 0; e.operand = 0;
    if (e.len == 2'd2) e.operand = mem[a1];
    if (e.len == 2'd3) begin
      {e.funct, e.regsel} = mem[a1];
      e.operand = mem[a2];
    end
    e.npc = base + {6'b0, e.len};
    return e;
  endfunction

  // Memory responder: one outstanding read, programmable grant/rvalid delay.
  bit         pend = 0;
  int         wcnt = 0, rv_cnt = 0;
  logic [7:0] paddr;
  initial begin
    mif.mem_gnt = 0; mif.mem_rvalid = 0; mif.mem_rdata = 0;
    forever begin
      @(posedge clk); #2;
      mif.mem_gnt = 0;
      mif.mem_rvalid = 0;
      if (spur) begin
        mif.mem_rvalid = 1; mif.mem_rdata = 8'hAB; spur = 0;
      end else if (pend) begin
        if (rv_cnt <= 1) begin
          mif.mem_rvalid = 1; mif.mem_rdata = mem[paddr]; pend = 0;
        end else rv_cnt--;
      end
      if (mif.mem_rd && !pend) begin
        if (wcnt >= gdly) begin
          mif.mem_gnt = 1; pend = 1; paddr = mif.mem_addr; rv_cnt = rdly; wcnt = 0;
        end else wcnt++;
      end
    end
  end

  // Per-cycle compare against the model.
  bit         prev_wait = 0;
  logic [7:0] prev_addr = 0, cmp_a;
  always @(negedge clk) begin
    if (reset) prev_wait = 0;
    else begin
      if (mif.mem_rd && prev_wait) chk("addr_stable", mif.mem_addr, prev_addr);
      if (mif.mem_rd && mif.mem_gnt) begin
        chk("read_expected", addr_q.size() > 0, 1);
        if (addr_q.size() > 0) begin
          cmp_a = addr_q.pop_front();
          chk("read_addr", mif.mem_addr, cmp_a);
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_expected", exp_valid, 1);
        chk("busy_at_done", busy, 0);
        chk("m_op", op, exp_r.op);
        chk("m_funct", funct, exp_r.funct);
        chk("m_regsel", regsel, exp_r.regsel);
        chk("m_operand", operand, exp_r.operand);
        chk("m_len", len, exp_r.len);
        chk("m_pc", pc, exp_r.npc);
        exp_valid = 0;
      end
      prev_wait = mif.mem_rd && !mif.mem_gnt;
      prev_addr = mif.mem_addr;
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic chk_rst(input string p);
    @(negedge clk); #1;
    chk({p, "_pc"}, pc, 8'h00);
    chk({p, "_op"}, op, 0);
    chk({p, "_funct"}, funct, 0);
    chk({p, "_regsel"}, regsel, 0);
    chk({p, "_operand"}, operand, 0);
    chk({p, "_len"}, len, 0);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_done"}, done, 0);
    chk({p, "_mem_rd"}, mif.mem_rd, 0);
    chk({p, "_mem_addr"}, mif.mem_addr, 0);
  endtask

  // Issue one fetch; lat counts cycles inclusively from the start cycle to the done cycle.
  task automatic do_fetch(input bit load, input logic [7:0] lval, input int gd, input int rd,
                          input bit noise, output int lat);
    logic [7:0] base;
    int d0, st;
    exp_t e;
    base = load ? lval : model_pc;
    e = predict(base);
    for (int i = 0; i < int'(e.len); i++) addr_q.push_back(base + 8'(i));
    exp_r = e; exp_valid = 1;
    gdly = gd; rdly = rd;
    d0 = done_cnt;
    tick;
    start = 1; pc_load = load; pc_load_val = lval; st = cyc;
    tick;
    start = 0; pc_load = 0;
    chk("busy_after_start", busy, 1);
    for (int n = 0; n < 200 && done_cnt == d0; n++) begin
      @(posedge clk); #1;
      if (noise) begin
        start = (n % 2 == 0); pc_load = (n % 3 == 0); pc_load_val = 8'h77;
      end
      @(negedge clk); #1;
    end
    start = 0; pc_load = 0;
    chk("done_seen", done_cnt != d0, 1);
    lat = done_cyc - st + 1;
    repeat (3) tick;
    chk("done_pulses", done_cnt - d0, 1);
    model_pc = e.npc;
  endtask

  int lat, d0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    foreach (mem[i]) mem[i] = 8'h00;
    mem[8'h00] = 8'h93;
    mem[8'h10] = 8'h24; mem[8'h11] = 8'h7F;
    mem[8'h20] = 8'hC0; mem[8'h21] = 8'hE3; mem[8'h22] = 8'h55;
    mem[8'hFE] = 8'hC4; mem[8'hFF] = 8'h25;
    mem[8'h30] = 8'hFC;
    mem[8'h31] = 8'h0C; mem[8'h32] = 8'h41; mem[8'h33] = 8'h22;
    mem[8'h34] = 8'h29; mem[8'h35] = 8'h80;
    mem[8'h40] = 8'hC8; mem[8'h41] = 8'h41; mem[8'h42] = 8'h42;

    reset = 1; start = 0; pc_load = 0; pc_load_val = 0;
    repeat (3) tick;
    reset = 0;
    chk_rst("rst");

    // POP at 0, single byte
    do_fetch(0, 8'h00, 0, 1, 0, lat);
    chk("t1_lat", lat, 4);
    chk("t1_op", op, 6'b100100);
    chk("t1_len", len, 1);
    chk("t1_pc", pc, 8'h01);

    // pc_load + start together, JMP
    do_fetch(1, 8'h10, 0, 1, 0, lat);
    chk("t2_lat", lat, 6);
    chk("t2_op", op, 6'b001001);
    chk("t2_operand", operand, 8'h7F);
    chk("t2_funct", funct, 0);
    chk("t2_len", len, 2);
    chk("t2_pc", pc, 8'h12);

    // ADD IMMED r3 with slow grant and slow data
    do_fetch(1, 8'h20, 2, 3, 0, lat);
    chk("t3_op", op, 6'b110000);
    chk("t3_funct", funct, 3'b111);
    chk("t3_regsel", regsel, 3);
    chk("t3_operand", operand, 8'h55);
    chk("t3_len", len, 3);
    chk("t3_pc", pc, 8'h23);

    // 3-byte instruction straddling the PC wrap
    do_fetch(1, 8'hFE, 0, 1, 0, lat);
    chk("t4_pc", pc, 8'h01);
    chk("t4_funct", funct, 1);
    chk("t4_regsel", regsel, 5);
    chk("t4_operand", operand, 8'h93);

    // pc_load alone in IDLE, then STOP and an unknown opcode
    tick;
    pc_load = 1; pc_load_val = 8'h30;
    tick;
    pc_load = 0;
    @(negedge clk); #1;
    chk("ld_pc", pc, 8'h30);
    model_pc = 8'h30;
    do_fetch(0, 8'h00, 0, 1, 0, lat);
    chk("stop_len", len, 1);
    chk("stop_operand", operand, 0);
    do_fetch(0, 8'h00, 0, 1, 0, lat);
    chk("unk_lat", lat, 8);
    chk("unk_len", len, 3);
    chk("unk_pc", pc, 8'h34);

    // start / pc_load noise while busy, then a spurious rvalid in IDLE
    do_fetch(0, 8'h00, 1, 2, 1, lat);
    chk("t5_pc", pc, 8'h36);
    chk("t5_op", op, 6'b001010);
    d0 = done_cnt;
    spur = 1;
    repeat (4) tick;
    @(negedge clk); #1;
    chk("spur_pc", pc, 8'h36);
    chk("spur_operand", operand, 8'h80);
    chk("spur_done", done_cnt - d0, 0);

    // reset during WAIT of byte 1, late rvalid afterwards
    exp_r = predict(8'h40); exp_valid = 1;
    addr_q.push_back(8'h40); addr_q.push_back(8'h41); addr_q.push_back(8'h42);
    gdly = 0; rdly = 4;
    d0 = done_cnt;
    tick;
    start = 1; pc_load = 1; pc_load_val = 8'h40;
    tick;
    start = 0; pc_load = 0;
    for (int n = 0; n < 100 && addr_q.size() > 1; n++) tick;
    chk("t6_byte1_granted", addr_q.size(), 1);
    reset = 1; exp_valid = 0; addr_q.delete();
    tick;
    reset = 0;
    chk_rst("midrst");
    repeat (8) tick;
    @(negedge clk); #1;
    chk("t6_no_done", done_cnt - d0, 0);
    chk("t6_pc", pc, 8'h00);
    model_pc = 8'h00;
    do_fetch(0, 8'h00, 0, 1, 0, lat);
    chk("t6_refetch_op", op, 6'b100100);
    chk("t6_refetch_pc", pc, 8'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch-side partner to the processor control FSM: on a fetch command it reads the instruction bytes at PC from byte-wide program memory.
- Decides the instruction length from the opcode byte, so 1, 2 or 3 bytes are read.
- Assembles op/funct/reg/operand fields, advances PC, and pulses done back to the control FSM.
- Sits between the control FSM and the program memory read port.

Parameters:
- AW, 8, program-memory address and PC width in bits.
- RESET_PC, 0, PC value after reset (AW bits).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  fetch command; sampled only in IDLE
- pc_load  in  1  load PC (jump/branch taken)
- pc_load_val  in  AW  new PC value
- mem_rd  out  1  read request; held until accepted
- mem_addr  out  AW  byte address; stable while mem_rd=1
- mem_gnt  in  1  memory accepts the request this cycle
- mem_rdata  in  8  read data
- mem_rvalid  in  1  mem_rdata valid; arrives 1 or more cycles after grant
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse when instruction fields are valid
- op  out  6  opcode
- funct  out  3  addressing mode
- regsel  out  5  register field
- operand  out  8  displacement, address or immediate
- len  out  2  bytes fetched (1..3)
- pc  out  AW  current PC

Behaviour:
- Byte format:
  - byte0[7:2]=op, byte0[1:0] ignored.
  - 2-byte class: byte1 = operand; funct and regsel are set to 0.
  - 3-byte class: byte1[7:5]=funct, byte1[4:0]=regsel, byte2 = operand.
- Length rule from op:
  - 1 byte: POP, PUSH, ASR, LSR, ASL, LSL, STOP (also set funct, regsel and operand to 0).
  - 2 bytes: JMP, BEQL, BNEQL.
  - 3 bytes: all other opcodes, including unknown ones.
- Reset: state=IDLE; pc=RESET_PC; mem_rd=0; mem_addr=0; busy=0; done=0; op=0; funct=0; regsel=0; operand=0; len=0.
- States: IDLE, REQ, WAIT, DONE. Byte counter idx counts 0..2.
  - IDLE: start=1 -> REQ with idx=0, busy=1.
  - REQ: mem_rd=1, mem_addr=pc. On mem_gnt -> WAIT.
  - WAIT: on mem_rvalid, capture the byte into the field selected by idx and set pc=pc+1 (mod 2^AW). If idx=0, latch len from the op in mem_rdata[7:2]. If more bytes remain, idx=idx+1 and go to REQ; otherwise go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- Fields of the previous instruction are held until overwritten. The new fetch clears op/funct/regsel/operand when it captures byte0.
- Minimum latency with grant and rvalid each on the next cycle: 1-byte instruction = 4 cycles from start to done; each extra byte adds 2 cycles.
- Only one read is outstanding at a time. mem_rvalid seen outside WAIT is ignored.
- pc_load:
  - Honoured only in IDLE; ignored while busy.
  - If pc_load and start are both high in IDLE, the load applies first and the fetch starts at pc_load_val. mem_addr in the next REQ equals pc_load_val.
- start while busy or in DONE is ignored (not queued).
- PC wrap: 2^AW-1 + 1 = 0. An instruction may straddle the wrap.
- Reset mid-fetch abandons the access: all outputs return to reset values next cycle, and a late mem_rvalid is ignored.

Decomposition:
- Package proc_pkg holds:
  - opcode constants: JMP, BEQL, BNEQL, LOAD, REGLOAD, POP, PUSH, ADD..NOT, ASR, LSR, ASL, LSL, STOP.
  - addressing-mode constants: REGDIR, MEMDIR, PCREL, IMMED.
  - fetch state enum.
  - length type.
  These are shared with the control FSM.
- One combinational sub-module, instr_len_decode: op[5:0] -> len[1:0].

Test Plan:
- Reset, then start, memory at 0 holds 0x93 (op=100100 POP), 1-cycle latency -> one read at addr 0; done 4 cycles after start; op=6'b100100, len=1, pc=1.
- pc_load=1 with pc_load_val=0x10 and start in the same cycle; mem[0x10..0x11]=0x24,0x7F (JMP) -> reads at 0x10 and 0x11; op=6'b001001, operand=0x7F, funct=0, len=2, pc=0x12.
- mem[0x20..0x22]=0xC0,0xE3,0x55 (ADD, IMMED, reg 3) with mem_gnt delayed 2 cycles and rvalid delayed 3 -> mem_rd and mem_addr held stable until grant; op=6'b110000, funct=3'b111, regsel=3, operand=0x55, len=3, single done pulse.
- PC=0xFE, 3-byte instruction -> reads at 0xFE, 0xFF, 0x00; final pc=0x01.
- Start pulses and a pc_load while busy, plus a spurious mem_rvalid in IDLE -> ignored; pc and fields unchanged; exactly one done.
- Reset asserted during WAIT of byte 1, with rvalid arriving afterwards -> outputs at reset values (pc=RESET_PC); no done; next start fetches normally.
